// File: rtl/ucb_pkg.sv
// Shared types and constants for the UCB arm-selection block.
// Q values are the UCB score scaled by 10 and carried as signed integers (no fractional bits).
package ucb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  parameter int unsigned NumArmsDefault = 8;
  parameter int unsigned QWDefault      = 32;

  // Most negative Q; any real result strictly above it displaces the initial best.
  parameter logic [QWDefault-1:0] QMin = 32'h8000_0000;

endpackage

// File: rtl/ucb_max_tracker.sv
// Running maximum of signed Q values with the arm index that produced it.
// Ties keep the earlier (lower-index) arm because the compare is strict.
module ucb_max_tracker #(
  parameter int unsigned ARM_W = 3,
  parameter int unsigned Q_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             cand_valid_i,
  input  logic [Q_W-1:0]   cand_q_i,
  input  logic [ARM_W-1:0] cand_arm_i,
  output logic [Q_W-1:0]   best_q_next_o,
  output logic [ARM_W-1:0] best_arm_next_o
);

  localparam logic [Q_W-1:0] QMinW = {1'b1, {(Q_W - 1){1'b0}}};

  logic [Q_W-1:0]   best_q_q, best_q_d;
  logic [ARM_W-1:0] best_arm_q, best_arm_d;

  always_comb begin
    best_q_d   = best_q_q;
    best_arm_d = best_arm_q;
    if (clear_i) begin
      best_q_d   = QMinW;
      best_arm_d = '0;
    end else if (cand_valid_i && ($signed(cand_q_i) > $signed(best_q_q))) begin
      best_q_d   = cand_q_i;
      best_arm_d = cand_arm_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_q_q   <= QMinW;
      best_arm_q <= '0;
    end else begin
      best_q_q   <= best_q_d;
      best_arm_q <= best_arm_d;
    end
  end

  // Exposing the next value lets the caller capture the final winner in the same edge.
  assign best_q_next_o   = best_q_d;
  assign best_arm_next_o = best_arm_d;

endmodule

// File: rtl/ucb_arm_select.sv
// Issues arm indices to the upstream Q pipeline, collects in-order results and reports the argmax.
// Optional watchdog abort is enabled by defining UCB_ARM_SELECT_TIMEOUT_EN.
module ucb_arm_select
  import ucb_pkg::*;
#(
  parameter int unsigned NUM_ARMS = NumArmsDefault,
  parameter int unsigned ARM_W    = $clog2(NUM_ARMS),
  parameter int unsigned Q_W      = QWDefault,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [ARM_W-1:0] req_arm,
  input  logic             res_valid,
  input  logic [Q_W-1:0]   res_q,
  output logic             sel_valid,
  output logic [ARM_W-1:0] sel_arm,
  output logic [Q_W-1:0]   sel_q,
  output logic             err
);

  localparam int unsigned       CntW    = $clog2(NUM_ARMS + 1);
  localparam logic [CntW-1:0]   LastCnt = CntW'(NUM_ARMS - 1);

  state_e state_q, state_d;

  logic [CntW-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]  res_cnt_q, res_cnt_d;
  logic [ARM_W-1:0] sel_arm_q, sel_arm_d;
  logic [Q_W-1:0]   sel_q_q, sel_q_d;
  logic             err_q, err_d;

  logic             start_acc, in_round, xfer, accept, last_xfer, last_res, timeout;
  logic [Q_W-1:0]   best_q_next;
  logic [ARM_W-1:0] best_arm_next;

  assign start_acc = (state_q == StIdle) && start;
  assign in_round  = (state_q == StIssue) || (state_q == StWait);
  assign xfer      = (state_q == StIssue) && req_ready;
  // Only results for arms already handed upstream count; strays are dropped.
  assign accept    = in_round && res_valid && (res_cnt_q < issue_cnt_q);
  assign last_xfer = xfer && (issue_cnt_q == LastCnt);
  assign last_res  = accept && (res_cnt_q == LastCnt);

`ifdef UCB_ARM_SELECT_TIMEOUT_EN
  localparam int unsigned     WdW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0]  WdFire = WdW'(TIMEOUT - 2);

  logic [WdW-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (start_acc || accept) begin
      wdog_d = '0;
    end else if (in_round) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // Abort on the cycle the idle count reaches TIMEOUT-1.
  assign timeout = in_round && !accept && (wdog_q == WdFire);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
`endif

  ucb_max_tracker #(
    .ARM_W (ARM_W),
    .Q_W   (Q_W)
  ) u_max_tracker (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_i         (start_acc),
    .cand_valid_i    (accept),
    .cand_q_i        (res_q),
    .cand_arm_i      (res_cnt_q[ARM_W-1:0]),
    .best_q_next_o   (best_q_next),
    .best_arm_next_o (best_arm_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StIssue;
      end
      StIssue: begin
        if (timeout) begin
          state_d = StDone;
        end else if (last_xfer) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (last_res || timeout) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = res_cnt_q;
    sel_arm_d   = sel_arm_q;
    sel_q_d     = sel_q_q;
    err_d       = err_q;
    if (start_acc) begin
      issue_cnt_d = '0;
      res_cnt_d   = '0;
      sel_arm_d   = '0;
      sel_q_d     = '0;
      err_d       = 1'b0;
    end else begin
      if (xfer) issue_cnt_d = issue_cnt_q + 1'b1;
      if (accept) res_cnt_d = res_cnt_q + 1'b1;
      if (timeout) err_d = 1'b1;
      if ((state_d == StDone) && (state_q != StDone)) begin
        sel_arm_d = best_arm_next;
        sel_q_d   = best_q_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      sel_arm_q   <= '0;
      sel_q_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      sel_arm_q   <= sel_arm_d;
      sel_q_q     <= sel_q_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    req_valid = (state_q == StIssue);
    req_arm   = req_valid ? issue_cnt_q[ARM_W-1:0] : '0;
    sel_valid = (state_q == StDone);
    sel_arm   = sel_arm_q;
    sel_q     = sel_q_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_ucb_arm_select.sv
// Scoreboard bench for ucb_arm_select with a 4-arm round and a 3-cycle upstream result delay.
// Watchdog scenarios run only when UCB_ARM_SELECT_TIMEOUT_EN is defined.
module tb_ucb_arm_select;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_arm;
  logic        res_valid;
  logic [31:0] res_q;
  logic        sel_valid;
  logic [1:0]  sel_arm;
  logic [31:0] sel_q;
  logic        err;

  ucb_arm_select #(
    .NUM_ARMS (4),
    .Q_W      (32),
    .TIMEOUT  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_arm   (req_arm),
    .res_valid (res_valid),
    .res_q     (res_q),
    .sel_valid (sel_valid),
    .sel_arm   (sel_arm),
    .sel_q     (sel_q),
    .err       (err)
  );

  typedef struct packed {
    logic [1:0]  arm;
    logic [31:0] q;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t        exp_q [$];
  int          checks       = 0;
  int          errors       = 0;
  int          cyc_cnt      = 0;
  int          sel_cnt      = 0;
  int          last_res_cyc = 0;
  logic [31:0] rv [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  // Monitor: pops the expected selection whenever the DUT announces one.
  initial begin
    exp_t e;
    bit   prev_sel;
    prev_sel = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_sel) check("sel_pulse_width", 32'(sel_valid), 32'd0);
      prev_sel = sel_valid;
      if (sel_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sel", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sel_arm", 32'(sel_arm), 32'(e.arm));
          check("sel_q", sel_q, e.q);
          check("err", 32'(err), 32'(e.err));
          check("sel_latency", 32'(cyc_cnt), 32'(last_res_cyc + int'(e.lat)));
        end
        sel_cnt++;
      end
    end
  end

  // Runs one round from rv[]; only the first n_res results are ever returned upstream.
  task automatic run_round(input int n_res, input logic [15:0] pat, input int pat_len,
                           input logic [1:0] e_arm, input logic [31:0] e_q, input logic e_err,
                           input int lat, input int abort_res);
    exp_t e;
    int   due [4];
    int   n_iss;
    int   delivered;
    int   sel0;
    bit   aborted;
    if (abort_res == 0) begin
      e.arm = e_arm;
      e.q   = e_q;
      e.err = e_err;
      e.lat = 8'(lat);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 4; i++) due[i] = -1;
    n_iss     = 0;
    delivered = 0;
    aborted   = 1'b0;
    sel0      = sel_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if ((sel_cnt != sel0) || aborted) break;
      req_ready = (k < pat_len) ? pat[k[3:0]] : 1'b1;
      res_valid = 1'b0;
      res_q     = '0;
      for (int i = 0; i < n_res; i++) begin
        if (due[i] == k) begin
          res_valid = 1'b1;
          res_q     = rv[i];
          delivered++;
          if (i == n_res - 1) last_res_cyc = cyc_cnt;
        end
      end
      @(negedge clk);
      if (k == 0) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_cleared_by_start", 32'(err), 32'd0);
      end
      if (req_valid) check("req_arm", 32'(req_arm), 32'(n_iss));
      if (req_valid && req_ready) begin
        if (n_iss < 4) due[n_iss] = k + 3;
        n_iss++;
      end
      @(posedge clk); #1;
      if ((abort_res > 0) && (delivered == abort_res)) aborted = 1'b1;
    end
    res_valid = 1'b0;
    res_q     = '0;
    req_ready = 1'b1;
    if (abort_res == 0) begin
      check("round_completed", 32'(sel_cnt - sel0), 32'd1);
      check("transfers", 32'(n_iss), 32'd4);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    req_ready = 1'b0;
    res_valid = 1'b0;
    res_q     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_arm", 32'(req_arm), 32'd0);
    check("rst_sel_valid", 32'(sel_valid), 32'd0);
    check("rst_sel_arm", 32'(sel_arm), 32'd0);
    check("rst_sel_q", sel_q, 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Basic argmax.
    rv = '{32'd10, 32'd50, 32'd30, 32'd20};
    run_round(4, 16'd0, 0, 2'd1, 32'd50, 1'b0, 1, 0);
    check("sel_arm_held", 32'(sel_arm), 32'd1);
    check("busy_back_idle", 32'(busy), 32'd0);

    // Ties keep the lowest index.
    rv = '{32'd40, 32'd40, 32'd10, 32'd40};
    run_round(4, 16'd0, 0, 2'd0, 32'd40, 1'b0, 1, 0);

    // Backpressure pattern 1,0,0,1,0,1,1 -> req_arm 0,1,1,1,2,2,3.
    rv = '{32'd3, 32'd9, 32'd27, 32'd8};
    run_round(4, 16'b1101001, 7, 2'd2, 32'd27, 1'b0, 1, 0);

    // Signed: -5,-3,-100,-7.
    rv = '{32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FF9C, 32'hFFFF_FFF9};
    run_round(4, 16'd0, 0, 2'd1, 32'hFFFF_FFFD, 1'b0, 1, 0);

    // Every result equals the most negative value: nothing beats the initial best.
    rv = '{ucb_pkg::QMin, ucb_pkg::QMin, ucb_pkg::QMin, ucb_pkg::QMin};
    run_round(4, 16'd0, 0, 2'd0, 32'h8000_0000, 1'b0, 1, 0);

    // Mid-round reset after two results, large values that must not leak into the next round.
    rv = '{32'd100, 32'd200, 32'd300, 32'd400};
    run_round(4, 16'd0, 0, 2'd0, 32'd0, 1'b0, 0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_valid", 32'(req_valid), 32'd0);
    check("mid_rst_req_arm", 32'(req_arm), 32'd0);
    check("mid_rst_sel_arm", 32'(sel_arm), 32'd0);
    check("mid_rst_sel_q", sel_q, 32'd0);
    @(posedge clk); #1;
    res_valid = 1'b1;
    res_q     = 32'd1000;
    @(negedge clk);
    check("stray_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    res_valid = 1'b0;
    res_q     = '0;
    @(negedge clk);
    check("stray_sel_valid", 32'(sel_valid), 32'd0);
    check("stray_sel_q", sel_q, 32'd0);
    rv = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_round(4, 16'd0, 0, 2'd3, 32'd8, 1'b0, 1, 0);

`ifdef UCB_ARM_SELECT_TIMEOUT_EN
    // Only two results ever return; watchdog aborts 16 cycles after the last one.
    rv = '{32'd7, 32'd9, 32'd0, 32'd0};
    run_round(2, 16'd0, 0, 2'd1, 32'd9, 1'b1, 16, 0);
    check("err_held", 32'(err), 32'd1);
    rv = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_round(4, 16'd0, 0, 2'd3, 32'd4, 1'b0, 1, 0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucb_arm_select.md
Name: ucb_arm_select

Overview:
- Downstream consumer of the UCB Q-function pipeline's fixed-point output (Q×10, signed 32-bit).
- Runs one selection round: issues arm indices 0..NUM_ARMS-1 to the upstream stats/Q pipeline, collects the in-order Q results, and reports the arm with the maximum Q.
- The output drives the arm-play controller.

Parameters:
- NUM_ARMS, 8, number of bandit arms per round (≥2).
- ARM_W, $clog2(NUM_ARMS), arm index width.
- Q_W, 32, width of the fixed-point Q value.
- TIMEOUT, 256, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a round; honoured only in IDLE.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- req_valid  out  1  arm request valid to the upstream Q pipeline.
- req_ready  in  1  upstream accepts the request (transfer when valid && ready).
- req_arm  out  ARM_W  arm index requested.
- res_valid  in  1  Q result valid; no backpressure, so it must be consumed the same cycle.
- res_q  in  Q_W  signed fixed-point Q result, in request order.
- sel_valid  out  1  one-cycle pulse: selection complete.
- sel_arm  out  ARM_W  winning arm; held until the next accepted start.
- sel_q  out  Q_W  winning Q value; held until the next accepted start.
- err  out  1  round aborted by watchdog; tied 0 when the feature is off.

Behaviour:
- Reset: state=IDLE; busy, req_valid, req_arm, sel_valid, sel_arm, sel_q, err all 0; counters 0.
- IDLE, start=1: go to ISSUE. Clear issue_cnt, res_cnt and err; best_q=Q_MIN (0x80000000); best_arm=0.
- ISSUE:
  - req_valid=1, req_arm=issue_cnt.
  - On a transfer, issue_cnt++. req_arm is stable while req_ready=0.
  - After transfer of arm NUM_ARMS-1: req_valid drops the next cycle; go to WAIT, or straight to DONE if all results are already in.
- Result acceptance, in ISSUE or WAIT only:
  - A result is accepted when res_valid && res_cnt < issue_cnt, using registered counts.
  - If res_q > best_q (signed, strict): best_q=res_q, best_arm=res_cnt.
  - res_cnt++ on every accepted result.
  - Ties keep the lower arm index.
- Ignored results: res_valid in IDLE/DONE, or with no outstanding request.
- WAIT: stay until the result for arm NUM_ARMS-1 is accepted, then go to DONE.
- DONE (one cycle):
  - sel_valid=1; sel_arm=best_arm and sel_q=best_q, registered.
  - Next cycle go to IDLE; busy=0.
- Latency: sel_valid asserts exactly 1 cycle after the final result is accepted.
- start while busy is ignored. start in the DONE cycle is ignored.
- Mid-round reset returns to the reset state. The upstream pipeline must be flushed before the next start; that is a system requirement, not checked here.

Optional Feature:
- Macro: UCB_ARM_SELECT_TIMEOUT_EN.
- With the macro:
  - A watchdog counter clears on ISSUE entry and on each accepted result, and increments otherwise in ISSUE/WAIT.
  - At count == TIMEOUT-1: go to DONE with err=1. sel_arm/sel_q = best among results received so far, or 0/Q_MIN if none.
  - err holds until the next accepted start.
- Without the macro: no counter; err is constant 0; a round may wait indefinitely.

Decomposition:
- Package ucb_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - Q_MIN constant;
  - default NUM_ARMS, Q_W;
  - Q_FRAC note (Q scaled ×10, integer fixed-point).
- Sub-module ucb_max_tracker: clear / load-if-greater register pair holding best_q and best_arm with signed strict compare. It is instantiated once.

Test Plan:
- NUM_ARMS=4, req_ready=1, results 10,50,30,20 each 3 cycles after request -> sel_arm=1, sel_q=50, sel_valid high exactly 1 cycle, 1 cycle after 4th result.
- Ties: results 40,40,10,40 -> sel_arm=0, sel_q=40.
- Backpressure: req_ready pattern 1,0,0,1,0,1,1 -> req_arm sequence 0,1,1,1,2,2,3; no skipped or duplicated transfers; final selection correct.
- Signed values: -5,-3,-100,-7 (0xFFFFFFFB,0xFFFFFFFD,0xFFFFFF9C,0xFFFFFFF9) -> sel_arm=1, sel_q=0xFFFFFFFD.
- Reset mid-round after 2 of 4 results:
  - outputs return to 0 and busy=0;
  - stray res_valid in IDLE is ignored;
  - a new round with 5,6,7,8 -> sel_arm=3, sel_q=8.
- Timeout (macro on, TIMEOUT=16): results 7,9 only -> err=1, sel_arm=1, sel_q=9, sel_valid 16 cycles after last result; start then clears err.
